// File: rtl/apb_arb_pkg.sv
// Shared state encoding and default widths for the two-requester APB arbiter.
package apb_arb_pkg;

    localparam int ARB_ADDR_W  = 7;
    localparam int ARB_DATA_W  = 32;
    localparam int ARB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_rr_pick2.sv
// Two-way round-robin picker: on a collision the requester that did not win last is granted.
module apb_rr_pick2
    import apb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            grant = ~last;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Two-requester APB master with round-robin arbitration and registered outputs.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_mem_arbiter
    import apb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = ARB_ADDR_W,
    parameter int DATA_WIDTH     = ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [1:0]              i_req,
    input  logic [1:0]              i_we,
    input  logic [2*ADDR_WIDTH-1:0] i_addr,
    input  logic [2*DATA_WIDTH-1:0] i_wdata,
    output logic [1:0]              o_done,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_err,
    output logic                    o_PSEL,
    output logic                    o_PENABLE,
    output logic                    o_PWRITE,
    output logic [ADDR_WIDTH-1:0]   o_PADDR,
    output logic [DATA_WIDTH-1:0]   o_PWDATA,
    input  logic                    i_PREADY,
    input  logic [DATA_WIDTH-1:0]   i_PRDATA,
    input  logic                    i_PSLVERR
);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETUP  = SETUP;
    localparam logic [1:0] S_ACCESS = ACCESS;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]            state;
    logic                  last;
    logic                  win;
    logic                  pick;
    logic                  pick_vld;
    logic                  tmo;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;
    logic                  we_sel;

    apb_rr_pick2 u_pick (
        .req   (i_req),
        .last  (last),
        .grant (pick),
        .valid (pick_vld)
    );

    always_comb begin
        addr_sel  = pick ? i_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]  : i_addr[ADDR_WIDTH-1:0];
        wdata_sel = pick ? i_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : i_wdata[DATA_WIDTH-1:0];
        we_sel    = pick ? i_we[1] : i_we[0];
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] acc_cnt;

    // Counts completed ACCESS cycles of the current transfer; cleared outside ACCESS.
    always_ff @(posedge i_clk) begin
        if (i_rst || state != S_ACCESS) begin
            acc_cnt <= '0;
        end else begin
            acc_cnt <= acc_cnt + 1'b1;
        end
    end

    assign tmo = (state == S_ACCESS) && !i_PREADY &&
                 (acc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            last      <= 1'b0;
            win       <= 1'b0;
            o_done    <= 2'b00;
            o_rdata   <= '0;
            o_err     <= 1'b0;
            o_PSEL    <= 1'b0;
            o_PENABLE <= 1'b0;
            o_PWRITE  <= 1'b0;
            o_PADDR   <= '0;
            o_PWDATA  <= '0;
        end else begin
            o_done <= 2'b00;
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        win      <= pick;
                        o_PWRITE <= we_sel;
                        o_PADDR  <= addr_sel;
                        o_PWDATA <= wdata_sel;
                        o_PSEL   <= 1'b1;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    o_PENABLE <= 1'b1;
                    state     <= S_ACCESS;
                end
                S_ACCESS: begin
                    // A real slave response takes priority over a coincident timeout.
                    if (i_PREADY || tmo) begin
                        o_PSEL      <= 1'b0;
                        o_PENABLE   <= 1'b0;
                        o_done[win] <= 1'b1;
                        o_err       <= i_PREADY ? i_PSLVERR : 1'b1;
                        if (i_PREADY && !o_PWRITE) begin
                            o_rdata <= i_PRDATA;
                        end
                        last  <= win;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
